// File: rtl/mnist_frame_loader.sv
// Streaming front end for the MNIST MLP accelerator: loads one 28x28 frame as Q8.24,
// starts the accelerator, waits for the result and returns it on a valid/ready channel.
module mnist_frame_loader #(
    parameter int N_PIX     = 784,
    parameter int PIX_SHIFT = 16,
    parameter int TIMEOUT   = 200000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic [N_PIX-1:0][31:0] image_pixels,
    output logic                   accel_start,
    input  logic                   accel_done,
    input  logic [3:0]             accel_digit,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [3:0]             r_digit,
    output logic [2:0]             r_err,
    output logic                   busy
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [9:0]        IDX_LAST = 10'(N_PIX - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_DRAIN,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [9:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_live;
    logic              w_beat;
    logic              w_idx_last;
    logic              w_load_res;
    logic [3:0]        w_res_digit;
    logic [2:0]        w_res_err;
    logic [31:0]       w_pix;

    // r_live keeps s_ready low while reset is held and for the release cycle
    assign s_ready     = r_live && (r_state == S_FILL || r_state == S_DRAIN);
    assign w_beat      = s_valid && s_ready;
    assign w_idx_last  = (r_idx == IDX_LAST);
    assign w_pix       = {24'd0, s_data} << PIX_SHIFT;
    assign accel_start = (r_state == S_START);
    assign busy        = (r_state == S_START) || (r_state == S_WAIT);
    assign r_valid     = (r_state == S_RESULT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load_res  = 1'b0;
        w_res_digit = 4'h0;
        w_res_err   = 3'b000;
        case (r_state)
            S_FILL: begin
                if (w_beat) begin
                    if (s_last && !w_idx_last) begin
                        w_next      = S_RESULT;
                        w_load_res  = 1'b1;
                        w_res_digit = 4'hF;
                        w_res_err   = 3'b001;
                    end else if (w_idx_last && s_last) begin
                        w_next = S_START;
                    end else if (w_idx_last) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_beat && s_last) begin
                    w_next      = S_RESULT;
                    w_load_res  = 1'b1;
                    w_res_digit = 4'hF;
                    w_res_err   = 3'b010;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                // completion wins over a timeout landing in the same cycle
                if (accel_done) begin
                    w_next      = S_RESULT;
                    w_load_res  = 1'b1;
                    w_res_digit = accel_digit;
                    w_res_err   = 3'b000;
                end else if (r_cnt == CNT_LAST) begin
                    w_next      = S_RESULT;
                    w_load_res  = 1'b1;
                    w_res_digit = 4'hF;
                    w_res_err   = 3'b100;
                end
            end
            S_RESULT: begin
                if (r_ready) w_next = S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            image_pixels <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_digit      <= 4'h0;
            r_err        <= 3'b000;
        end else begin
            if (r_state == S_FILL && w_beat) begin
                image_pixels[r_idx] <= w_pix;
                if (w_next == S_FILL) r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_RESULT && r_ready) r_idx <= '0;
            if (r_state == S_START)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_load_res) begin
                r_digit <= w_res_digit;
                r_err   <= w_res_err;
            end
        end
    end

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Bench for mnist_frame_loader: random frames against a frame-level pixel/result model.
module tb_mnist_frame_loader;

    localparam int N_PIX = 784;
    localparam int TMO   = 100;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [7:0]             s_data = 8'd0;
    logic                   s_last = 1'b0;
    logic [N_PIX-1:0][31:0] image_pixels;
    logic                   accel_start;
    logic                   accel_done = 1'b0;
    logic [3:0]             accel_digit = 4'd0;
    logic                   r_valid;
    logic                   r_ready = 1'b0;
    logic [3:0]             r_digit;
    logic [2:0]             r_err;
    logic                   busy;

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    int          bad_idx;
    logic [31:0] exp_pix [N_PIX];
    logic [7:0]  fd [800];

    always #5 clk = ~clk;

    always @(posedge clk) if (accel_start) start_cnt++;

    mnist_frame_loader #(.N_PIX(N_PIX), .PIX_SHIFT(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .image_pixels(image_pixels), .accel_start(accel_start),
        .accel_done(accel_done), .accel_digit(accel_digit),
        .r_valid(r_valid), .r_ready(r_ready), .r_digit(r_digit), .r_err(r_err),
        .busy(busy)
    );

    function automatic int pix_bad();
        int n = 0;
        bad_idx = -1;
        for (int i = 0; i < N_PIX; i++) begin
            if (image_pixels[i] !== exp_pix[i]) begin
                if (n == 0) bad_idx = i;
                n++;
            end
        end
        return n;
    endfunction

    // Called and returns at a negedge; returns right after the last beat's accepting edge.
    task automatic send_frame(input int len, input bit rnd);
        int n;
        for (int i = 0; i < len; i++) fd[i] = rnd ? 8'($urandom) : 8'(i % 256);
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = fd[i];
            s_last  = (i == len - 1);
            n = 0;
            while (!s_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!s_ready) begin
                checks++; errors++;
                $display("FAIL beat_accept beat %0d: s_ready stayed 0, required 1", i);
                s_valid = 1'b0; s_last = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int i = 0; i < len && i < N_PIX; i++) exp_pix[i] = {8'd0, fd[i], 16'd0};
    endtask

    task automatic handshake();
        r_ready = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N_PIX; i++) exp_pix[i] = 32'd0;
        @(negedge clk);
        checks++;
        if ({s_ready, accel_start, r_valid, busy, r_digit, r_err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b st=%b rv=%b busy=%b dig=%h err=%b, required all 0",
                     s_ready, accel_start, r_valid, busy, r_digit, r_err);
        end
        checks++;
        if (pix_bad() !== 0) begin
            errors++;
            $display("FAIL reset_pixels word %0d = %h, required 0", bad_idx, image_pixels[bad_idx]);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 1", s_ready);
        end
    endtask

    task automatic test_good_frame();
        int sc = start_cnt;
        send_frame(N_PIX, 1'b0);
        checks++;
        if (accel_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL good_start_pulse got start=%b busy=%b required 1 1", accel_start, busy);
        end
        checks++;
        if (image_pixels[300] !== 32'h002C0000) begin
            errors++;
            $display("FAIL good_pix300 got %h required 002c0000", image_pixels[300]);
        end
        checks++;
        if (pix_bad() !== 0) begin
            errors++;
            $display("FAIL good_pixels word %0d got %h required %h", bad_idx, image_pixels[bad_idx], exp_pix[bad_idx]);
        end
        @(negedge clk);
        checks++;
        if (accel_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL good_start_width got start=%b busy=%b required 0 1", accel_start, busy);
        end
        repeat (48) @(negedge clk);
        accel_done = 1'b1; accel_digit = 4'd7;
        @(negedge clk);
        accel_done = 1'b0;
        checks++;
        if (r_valid !== 1'b1 || busy !== 1'b0 || r_digit !== 4'd7 || r_err !== 3'b000) begin
            errors++;
            $display("FAIL good_result got rv=%b busy=%b dig=%h err=%b required 1 0 7 000", r_valid, busy, r_digit, r_err);
        end
        checks++;
        if (start_cnt - sc !== 1) begin
            errors++;
            $display("FAIL good_start_count got %0d required 1", start_cnt - sc);
        end
        handshake();
        checks++;
        if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL good_handshake got rv=%b rdy=%b required 0 1", r_valid, s_ready);
        end
    endtask

    task automatic test_short_frame();
        int sc = start_cnt;
        send_frame(100, 1'b1);
        checks++;
        if (r_valid !== 1'b1 || r_err !== 3'b001 || r_digit !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_result got rv=%b err=%b dig=%h busy=%b required 1 001 f 0", r_valid, r_err, r_digit, busy);
        end
        checks++;
        if (pix_bad() !== 0) begin
            errors++;
            $display("FAIL short_pixels word %0d got %h required %h", bad_idx, image_pixels[bad_idx], exp_pix[bad_idx]);
        end
        handshake();
        checks++;
        if (s_ready !== 1'b1 || start_cnt !== sc) begin
            errors++;
            $display("FAIL short_after got rdy=%b starts=%0d required 1 %0d", s_ready, start_cnt, sc);
        end
    endtask

    task automatic test_long_frame();
        int sc = start_cnt;
        send_frame(790, 1'b1);
        checks++;
        if (r_valid !== 1'b1 || r_err !== 3'b010 || r_digit !== 4'hF) begin
            errors++;
            $display("FAIL long_result got rv=%b err=%b dig=%h required 1 010 f", r_valid, r_err, r_digit);
        end
        checks++;
        if (pix_bad() !== 0) begin
            errors++;
            $display("FAIL long_pixels word %0d got %h required %h", bad_idx, image_pixels[bad_idx], exp_pix[bad_idx]);
        end
        checks++;
        if (start_cnt !== sc) begin
            errors++;
            $display("FAIL long_no_start got %0d starts required %0d", start_cnt, sc);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int k = 0;
        send_frame(N_PIX, 1'b1);
        checks++;
        if (accel_start !== 1'b1) begin
            errors++;
            $display("FAIL tmo_start got %b required 1", accel_start);
        end
        while (!r_valid && k < 3 * TMO) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== TMO + 1) begin
            errors++;
            $display("FAIL tmo_latency got %0d edges after start required %0d", k, TMO + 1);
        end
        checks++;
        if (r_err !== 3'b100 || r_digit !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_result got err=%b dig=%h busy=%b required 100 f 0", r_err, r_digit, busy);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            logic [3:0] d = 4'($urandom);
            int dly = $urandom_range(1, 80);
            send_frame(N_PIX, 1'b1);
            accel_done = 1'b1; accel_digit = ~d;
            @(negedge clk);
            accel_done = 1'b0;
            checks++;
            if (r_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done_in_start got rv=%b busy=%b required 0 1", r_valid, busy);
            end
            repeat (dly) @(negedge clk);
            accel_done = 1'b1; accel_digit = d;
            @(negedge clk);
            accel_done = 1'b0;
            checks++;
            if (r_valid !== 1'b1 || r_digit !== d || r_err !== 3'b000) begin
                errors++;
                $display("FAIL b2b_result frame %0d got rv=%b dig=%h err=%b required 1 %h 000", f, r_valid, r_digit, r_err, d);
            end
            checks++;
            if (pix_bad() !== 0) begin
                errors++;
                $display("FAIL b2b_pixels word %0d got %h required %h", bad_idx, image_pixels[bad_idx], exp_pix[bad_idx]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] d = 4'($urandom_range(10, 15));
        int bad = 0;
        send_frame(N_PIX, 1'b1);
        repeat ($urandom_range(2, 30)) @(negedge clk);
        accel_done = 1'b1; accel_digit = d;
        @(negedge clk);
        accel_done = 1'b0;
        accel_digit = 4'($urandom);
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || r_valid !== 1'b1 || r_digit !== d || r_err !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got rdy=%b rv=%b dig=%h err=%b required 0 1 %h 000",
                         c, s_ready, r_valid, r_digit, r_err, d);
            end
        end
        s_last = 1'b0;
        handshake();
        send_frame(N_PIX, 1'b1);
        repeat (5) @(negedge clk);
        accel_done = 1'b1; accel_digit = 4'd2;
        @(negedge clk);
        accel_done = 1'b0;
        checks++;
        if (pix_bad() !== 0 || r_digit !== 4'd2) begin
            errors++;
            $display("FAIL bp_next_frame word %0d got %h required %h, dig=%h required 2",
                     bad_idx, bad_idx >= 0 ? image_pixels[bad_idx] : 32'd0,
                     bad_idx >= 0 ? exp_pix[bad_idx] : 32'd0, r_digit);
        end
        handshake();
    endtask

    task automatic test_reset_in_wait();
        int sc;
        send_frame(N_PIX, 1'b1);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < N_PIX; i++) exp_pix[i] = 32'd0;
        #1;
        checks++;
        if ({s_ready, accel_start, r_valid, busy, r_digit, r_err} !== 11'd0) begin
            errors++;
            $display("FAIL rst_wait_outputs got rdy=%b st=%b rv=%b busy=%b dig=%h err=%b required all 0",
                     s_ready, accel_start, r_valid, busy, r_digit, r_err);
        end
        checks++;
        if (pix_bad() !== 0) begin
            errors++;
            $display("FAIL rst_wait_pixels word %0d = %h required 0", bad_idx, image_pixels[bad_idx]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        sc = start_cnt;
        accel_done = 1'b1; accel_digit = 4'd5;
        repeat (5) @(negedge clk);
        accel_done = 1'b0;
        checks++;
        if (r_valid !== 1'b0 || busy !== 1'b0 || start_cnt !== sc || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_done_ignored got rv=%b busy=%b starts=%0d rdy=%b required 0 0 %0d 1",
                     r_valid, busy, start_cnt, s_ready, sc);
        end
        send_frame(N_PIX, 1'b1);
        repeat (3) @(negedge clk);
        accel_done = 1'b1; accel_digit = 4'd9;
        @(negedge clk);
        accel_done = 1'b0;
        checks++;
        if (r_valid !== 1'b1 || r_digit !== 4'd9 || pix_bad() !== 0) begin
            errors++;
            $display("FAIL rst_wait_new_frame got rv=%b dig=%h badpix=%0d required 1 9 0", r_valid, r_digit, pix_bad());
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_good_frame();
        test_long_frame();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mnist_frame_loader.md
# mnist_frame_loader

Front-end streaming loader for the MNIST MLP accelerator. It accepts one 28x28 grayscale image as an 8-bit pixel stream and converts each pixel to Q8.24. It holds the 784-word image stable on the accelerator's `image_pixels` input, pulses the accelerator's `start`, and waits for completion. It then returns the predicted digit, plus error flags, to the host on a valid/ready result channel.

## Interface

- `N_PIX`, 784: pixels per frame (row-major, index 0 = top-left).
- `PIX_SHIFT`, 16: left shift applied to the 8-bit pixel to form Q8.24 (p -> p/256).
- `TIMEOUT`, 200000: max cycles in WAIT before a timeout result.

Ports:

- `clk`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  pixel beat valid.
- `s_ready`  out  1  loader can accept a beat.
- `s_data`  in  8  unsigned pixel value.
- `s_last`  in  1  final beat of frame.
- `image_pixels`  out  32 x N_PIX  signed Q8.24 pixel array, wired to the accelerator.
- `accel_start`  out  1  one-cycle start pulse to the accelerator.
- `accel_done`  in  1  accelerator completion (pulse or level).
- `accel_digit`  in  4  accelerator predicted_digit.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  host accepts result.
- `r_digit`  out  4  predicted digit; 4'hF on any error.
- `r_err`  out  3  [0] short frame, [1] long frame, [2] accelerator timeout.
- `busy`  out  1  high in START and WAIT.

## Operation

- States: FILL, DRAIN, START, WAIT, RESULT. Reset state is FILL.
- `s_ready` = 1 in FILL and DRAIN, else 0. A beat is accepted on `s_valid && s_ready`.
- Pixel index `idx` is 10-bit, 0 to N_PIX-1, reset 0.
- FILL, accepted beat:
  - Write `image_pixels[idx] <= {8'd0, s_data, 16'd0}`. For general PIX_SHIFT the value is zero-extended `s_data << PIX_SHIFT`. The result is always non-negative.
  - If `s_last` and idx < N_PIX-1: short frame. Go to RESULT with r_err=3'b001, r_digit=4'hF. The accelerator is not started.
  - If idx == N_PIX-1 and `s_last`: go to START.
  - If idx == N_PIX-1 and not `s_last`: long frame. Go to DRAIN.
  - Otherwise idx++.
- DRAIN: discard accepted beats. The beat carrying `s_last` sends the FSM to RESULT with r_err=3'b010, r_digit=4'hF.
- START: `accel_start` = 1 for exactly this cycle. Clear the timeout counter. Next state is WAIT.
- WAIT:
  - `accel_done` is sampled only in WAIT; done high during START is ignored.
  - On done: capture `accel_digit` into r_digit, set r_err=0, go to RESULT.
  - Otherwise the counter increments. Counter width is $clog2(TIMEOUT+1).
  - Reaching TIMEOUT sends the FSM to RESULT with r_err=3'b100, r_digit=4'hF.
- RESULT: `r_valid` = 1, with r_digit and r_err held stable until `r_ready`. On the handshake, go to FILL and set idx=0.
- `image_pixels` changes only on FILL writes and reset. It is stable from START through RESULT. Old pixels persist until overwritten.
- `accel_digit` values greater than 9 are passed through unmodified, with no error flagged.

## Timing

- Reset (async assert, sync to FSM on release) sets:
  - state FILL, idx 0;
  - every `image_pixels` word 0;
  - `accel_start` 0, `r_valid` 0, `r_digit` 0, `r_err` 0, `busy` 0;
  - `s_ready` 0 while `reset_n` is low.
- Throughput in FILL is one beat per cycle. A full frame needs at least 784 cycles.
- Last beat accepted at edge T: `accel_start` high in cycle T+1, `busy` high from T+1.
- `accel_done` seen at edge D: `r_valid` high from D+1, and `busy` low from D+1.
- Error result: `r_valid` high the cycle after the terminating beat is accepted.
- Result handshake at edge H: `r_valid` low and `s_ready` high from H+1. There is no combinational path from `r_ready` to `s_ready`.
- `r_valid` never drops without `r_ready`. `r_digit`/`r_err` never change while `r_valid` is high.
- Reset mid-frame or mid-WAIT aborts immediately. No `accel_start` and no result are produced for the aborted frame.

## Test plan

- Good frame: pixels p[i] = i mod 256, s_last on beat 783, back-to-back. Required:
  - `image_pixels[300]` = 32'h002C0000;
  - `accel_start` high one cycle, one cycle after the last beat.
  - Then drive accel_done after 50 cycles with accel_digit=7 -> r_valid the next cycle, r_digit=7, r_err=0.
- Short frame: s_last on beat 99 -> r_err=001, r_digit=F, accel_start never asserted. After r_ready, s_ready=1 and idx restarts at 0.
- Long frame: 790 beats with s_last on beat 789 -> beats 784..789 are dropped and image_pixels[0..783] is unchanged by them. Result r_err=010, r_digit=F.
- Timeout: TIMEOUT=100, accel_done held low -> r_valid exactly 100 cycles after entering WAIT, r_err=100, r_digit=F.
- Backpressure: hold r_ready low for 20 cycles with s_valid high throughout -> s_ready stays 0, r_digit/r_err stay stable, no beats are lost. The next frame loads correctly after the handshake.
- Reset during WAIT, then assert accel_done after release -> done ignored, r_valid stays 0, all outputs at reset values, FILL accepts a new frame.
